// File: rtl/dat_playback_ctrl.sv
// dat_playback_ctrl: streams a window of a pre-loaded sample RAM onto a valid/ready
// port, repeating the window a programmable number of passes, with abort support.
module dat_playback_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int LOOP_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_length,
  input  logic [LOOP_W-1:0] i_loops,
  output logic              o_mem_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic [DATA_W-1:0] o_tdata,
  output logic              o_tvalid,
  input  logic              i_tready,
  output logic              o_tlast,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_dbg_state
);

  // Stream handshake: a beat transfers on every rising edge where o_tvalid and
  // i_tready are both high; once raised, o_tvalid/o_tdata/o_tlast hold until then.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] base_q, len_m1_q, idx_q;
  logic [LOOP_W-1:0] loops_q, pass_q;
  logic              infl_q, infl_last_q;
  logic [DATA_W-1:0] fifo_data [2];
  logic              fifo_last [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        count_q;

  logic              pop, room, last_idx, last_pass, issue;
  logic [1:0]        occ;

  assign pop       = o_tvalid & i_tready;
  // Slots already claimed after this cycle's pop; a read may only issue into a free one.
  assign occ       = count_q + {1'b0, infl_q} - {1'b0, pop};
  assign room      = (occ < 2'd2);
  assign last_idx  = (idx_q == len_m1_q);
  assign last_pass = (loops_q != '0) && (pass_q == loops_q - LOOP_W'(1));

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) state_d = (i_length == '0) ? DONE : RUN;
      end
      RUN: begin
        issue = room;
        if (room && last_idx && last_pass) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && (count_q == 2'd1) && !infl_q) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_abort) begin
      state_d = IDLE;
      issue   = 1'b0;
    end
  end

  assign o_mem_en    = issue;
  assign o_mem_addr  = base_q + idx_q;
  assign o_tvalid    = (count_q != 2'd0);
  assign o_tdata     = fifo_data[rd_ptr_q];
  assign o_tlast     = fifo_last[rd_ptr_q];
  assign o_busy      = (state_q != IDLE);
  assign o_done      = (state_q == DONE);
  assign o_dbg_state = state_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      base_q       <= '0;
      len_m1_q     <= '0;
      loops_q      <= '0;
      idx_q        <= '0;
      pass_q       <= '0;
      infl_q       <= 1'b0;
      infl_last_q  <= 1'b0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last[0] <= 1'b0;
      fifo_last[1] <= 1'b0;
    end else if (i_abort) begin
      // The read in flight is dropped by clearing its marker; its data is never pushed.
      infl_q   <= 1'b0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if ((state_q == IDLE) && i_start) begin
        base_q   <= i_base_addr;
        len_m1_q <= ADDR_W'(i_length - (ADDR_W+1)'(1));
        loops_q  <= i_loops;
        idx_q    <= '0;
        pass_q   <= '0;
      end
      if (issue) begin
        if (last_idx) begin
          idx_q  <= '0;
          pass_q <= pass_q + LOOP_W'(1);
        end else begin
          idx_q  <= idx_q + ADDR_W'(1);
        end
      end
      infl_q      <= issue;
      infl_last_q <= last_idx;
      if (infl_q) begin
        fifo_data[wr_ptr_q] <= i_mem_data;
        fifo_last[wr_ptr_q] <= infl_last_q;
        wr_ptr_q            <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, infl_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_dat_playback_ctrl.sv
// tb_dat_playback_ctrl: self-checking bench for the sample-RAM playback sequencer,
// with a RAM model, a per-cycle vector table, directed corner sequences and random jobs.
module tb_dat_playback_ctrl;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;
  localparam int LOOP_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              i_rst, i_start, i_abort, i_tready;
  logic [ADDR_W-1:0] i_base_addr;
  logic [ADDR_W:0]   i_length;
  logic [LOOP_W-1:0] i_loops;
  logic [DATA_W-1:0] i_mem_data;
  logic              o_mem_en, o_tvalid, o_tlast, o_busy, o_done;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_tdata;
  logic [1:0]        o_dbg_state;

  // ---------------- clock / reset / DUT ----------------
  always #5 clk = ~clk;

  dat_playback_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LOOP_W(LOOP_W)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_base_addr(i_base_addr), .i_length(i_length), .i_loops(i_loops),
    .o_mem_en(o_mem_en), .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .i_tready(i_tready), .o_tlast(o_tlast),
    .o_busy(o_busy), .o_done(o_done), .o_dbg_state(o_dbg_state)
  );

  // Sample RAM: one-cycle read latency, junk on the data bus when not enabled.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) i_mem_data <= o_mem_en ? mem[o_mem_addr] : DATA_W'($urandom);

  // ---------------- scoreboard ----------------
  int n_cmp = 0, n_err = 0, n_beats = 0, n_done = 0;
  logic [DATA_W:0] exp_q[$];
  int rdy_mode = 0;
  int rdy_ph = 0;
  logic [3:0] rdy_pat = 4'b1001;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic prev_stall = 1'b0;
  logic [DATA_W:0] prev_beat = '0;
  always @(negedge clk) begin
    if (prev_stall) begin
      check("stall_valid", 32'(o_tvalid), 32'd1);
      check("stall_hold", 32'({o_tlast, o_tdata}), 32'(prev_beat));
    end
    if (o_tvalid && i_tready) begin
      n_beats++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL extra_beat: got 0x%0h expected no beat at %0t", {o_tlast, o_tdata}, $time);
      end else begin
        check("beat", 32'({o_tlast, o_tdata}), 32'(exp_q.pop_front()));
      end
    end
    if (o_done) n_done++;
    prev_stall = o_tvalid && !i_tready && !i_abort && !i_rst;
    prev_beat  = {o_tlast, o_tdata};
  end

  // Reference: each pass emits mem[(base+i) mod DEPTH] for i = 0..len-1, last flag on i = len-1.
  task automatic model_job(input logic [ADDR_W-1:0] base, input int len, input int loops);
    for (int p = 0; p < loops; p++) begin
      for (int i = 0; i < len; i++) begin
        exp_q.push_back({(i == len - 1), mem[(int'(base) + i) % DEPTH]});
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: i_tready = 1'b1;
      1: i_tready = 1'($urandom_range(0, 1));
      2: begin
        i_tready = rdy_pat[rdy_ph];
        rdy_ph   = (rdy_ph + 1) % 4;
      end
      3: i_tready = 1'b0;
      default: ;
    endcase
  endtask

  task automatic run_job(input logic [ADDR_W-1:0] base, input int len, input int loops,
                         input int mode, input bit noise);
    int cnt;
    model_job(base, len, loops);
    n_beats  = 0;
    n_done   = 0;
    rdy_mode = mode;
    step();
    i_start = 1'b1; i_base_addr = base;
    i_length = (ADDR_W+1)'(len); i_loops = LOOP_W'(loops);
    step();
    i_start = 1'b0;
    cnt = 0;
    while (o_busy && cnt < len * loops * 8 + 40) begin
      i_base_addr = ADDR_W'($urandom);
      i_length    = (ADDR_W+1)'($urandom);
      i_loops     = LOOP_W'($urandom);
      step();
      i_start = noise && o_busy && ($urandom_range(0, 5) == 0);
      cnt++;
    end
    i_start = 1'b0;
    check("job_idle", 32'(o_busy), 32'd0);
    check("job_left", exp_q.size(), 32'd0);
    check("job_beats", n_beats, len * loops);
    check("job_done", n_done, 32'd1);
    exp_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic              start, abort, ready;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   len;
    logic [LOOP_W-1:0] loops;
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic              tv, tl;
    logic [ADDR_W-1:0] da;
    logic              bz, dn;
  } vec_t;

  function automatic vec_t mk(input logic st, ab, rdy, input logic [ADDR_W-1:0] base,
                              input logic [ADDR_W:0] len, input logic [LOOP_W-1:0] loops,
                              input logic en, input logic [ADDR_W-1:0] addr,
                              input logic tv, tl, input logic [ADDR_W-1:0] da,
                              input logic bz, dn);
    vec_t v;
    v.start = st; v.abort = ab; v.ready = rdy; v.base = base; v.len = len; v.loops = loops;
    v.en = en; v.addr = addr; v.tv = tv; v.tl = tl; v.da = da; v.bz = bz; v.dn = dn;
    return v;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    vec_t vecs[$];
    int cnt;
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i * 40503 + 777);
    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_tready = 1'b0;
    i_base_addr = '0; i_length = '0; i_loops = '0;

    repeat (3) step();
    i_rst = 1'b0;
    @(negedge clk);
    check("rst_mem_en", 32'(o_mem_en), 32'd0);
    check("rst_addr", 32'(o_mem_addr), 32'd0);
    check("rst_tdata", 32'(o_tdata), 32'd0);
    check("rst_tvalid", 32'(o_tvalid), 32'd0);
    check("rst_tlast", 32'(o_tlast), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);

    // Cycle-exact table: single pass latency, zero-length start, abort beating start.
    vecs.push_back(mk(1, 0, 1, 10'h010, 11'd4, 8'd1, 0, 10'h000, 0, 0, 10'h000, 0, 0));
    vecs.push_back(mk(0, 0, 1, 10'h010, 11'd4, 8'd1, 1, 10'h010, 0, 0, 10'h000, 1, 0));
    vecs.push_back(mk(0, 0, 1, 10'h010, 11'd4, 8'd1, 1, 10'h011, 0, 0, 10'h000, 1, 0));
    vecs.push_back(mk(0, 0, 1, 10'h010, 11'd4, 8'd1, 1, 10'h012, 1, 0, 10'h010, 1, 0));
    vecs.push_back(mk(0, 0, 1, 10'h010, 11'd4, 8'd1, 1, 10'h013, 1, 0, 10'h011, 1, 0));
    vecs.push_back(mk(0, 0, 1, 10'h010, 11'd4, 8'd1, 0, 10'h000, 1, 0, 10'h012, 1, 0));
    vecs.push_back(mk(0, 0, 1, 10'h010, 11'd4, 8'd1, 0, 10'h000, 1, 1, 10'h013, 1, 0));
    vecs.push_back(mk(0, 0, 1, 10'h010, 11'd4, 8'd1, 0, 10'h000, 0, 0, 10'h000, 1, 1));
    vecs.push_back(mk(0, 0, 1, 10'h010, 11'd4, 8'd1, 0, 10'h000, 0, 0, 10'h000, 0, 0));
    vecs.push_back(mk(1, 0, 1, 10'h200, 11'd0, 8'd1, 0, 10'h000, 0, 0, 10'h000, 0, 0));
    vecs.push_back(mk(0, 0, 1, 10'h200, 11'd0, 8'd1, 0, 10'h000, 0, 0, 10'h000, 1, 1));
    vecs.push_back(mk(0, 0, 1, 10'h200, 11'd0, 8'd1, 0, 10'h000, 0, 0, 10'h000, 0, 0));
    vecs.push_back(mk(1, 1, 1, 10'h020, 11'd4, 8'd1, 0, 10'h000, 0, 0, 10'h000, 0, 0));
    vecs.push_back(mk(0, 0, 1, 10'h020, 11'd4, 8'd1, 0, 10'h000, 0, 0, 10'h000, 0, 0));
    vecs.push_back(mk(0, 0, 1, 10'h020, 11'd4, 8'd1, 0, 10'h000, 0, 0, 10'h000, 0, 0));
    model_job(10'h010, 4, 1);
    rdy_mode = 4;
    foreach (vecs[k]) begin
      step();
      i_start = vecs[k].start; i_abort = vecs[k].abort; i_tready = vecs[k].ready;
      i_base_addr = vecs[k].base; i_length = vecs[k].len; i_loops = vecs[k].loops;
      @(negedge clk);
      check($sformatf("v%0d_mem_en", k), 32'(o_mem_en), 32'(vecs[k].en));
      if (vecs[k].en) check($sformatf("v%0d_addr", k), 32'(o_mem_addr), 32'(vecs[k].addr));
      check($sformatf("v%0d_tvalid", k), 32'(o_tvalid), 32'(vecs[k].tv));
      if (vecs[k].tv)
        check($sformatf("v%0d_beat", k), 32'({o_tlast, o_tdata}), 32'({vecs[k].tl, mem[vecs[k].da]}));
      check($sformatf("v%0d_busy", k), 32'(o_busy), 32'(vecs[k].bz));
      check($sformatf("v%0d_done", k), 32'(o_done), 32'(vecs[k].dn));
    end
    i_start = 1'b0; i_abort = 1'b0;
    check("table_left", exp_q.size(), 32'd0);
    exp_q.delete();

    // Address wrap across the top of memory, two passes.
    run_job(10'h3FE, 4, 2, 0, 0);
    // Backpressure: fixed 1,0,0,1 pattern, then random ready.
    run_job(10'h0A5, 8, 1, 2, 0);
    run_job(10'h1F0, 8, 1, 1, 1);

    // Infinite loop, abort after 40 beats, then a clean replay from the same base.
    model_job(10'h100, 16, 3);
    n_beats = 0; n_done = 0; rdy_mode = 0;
    step();
    i_start = 1'b1; i_base_addr = 10'h100; i_length = 11'd16; i_loops = 8'd0;
    step();
    i_start = 1'b0;
    cnt = 0;
    while (n_beats < 40 && cnt < 200) begin
      step();
      cnt++;
    end
    check("abort_beats", n_beats, 32'd40);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    @(negedge clk);
    check("abort_tvalid", 32'(o_tvalid), 32'd0);
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_mem_en", 32'(o_mem_en), 32'd0);
    exp_q.delete();
    repeat (6) step();
    check("abort_no_done", n_done, 32'd0);
    run_job(10'h100, 16, 1, 0, 0);

    // Reset while one word sits in the buffer and another read is in flight.
    n_done = 0; rdy_mode = 3;
    step();
    i_start = 1'b1; i_base_addr = 10'h2C0; i_length = 11'd8; i_loops = 8'd1;
    step();
    i_start = 1'b0;
    step();
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    @(negedge clk);
    check("rst2_mem_en", 32'(o_mem_en), 32'd0);
    check("rst2_addr", 32'(o_mem_addr), 32'd0);
    check("rst2_tdata", 32'(o_tdata), 32'd0);
    check("rst2_tvalid", 32'(o_tvalid), 32'd0);
    check("rst2_tlast", 32'(o_tlast), 32'd0);
    check("rst2_busy", 32'(o_busy), 32'd0);
    check("rst2_done", 32'(o_done), 32'd0);
    rdy_mode = 0;
    repeat (4) step();
    check("rst2_no_done", n_done, 32'd0);
    run_job(10'h155, 8, 1, 1, 0);

    // Full-memory window, then random jobs with busy-time start noise.
    run_job(10'h123, DEPTH, 1, 0, 0);
    for (int j = 0; j < 14; j++) begin
      int len;
      int loops;
      logic [ADDR_W-1:0] b;
      b     = ADDR_W'($urandom);
      len   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2) : $urandom_range(1, 40);
      loops = $urandom_range(1, 3);
      run_job(b, len, loops, $urandom_range(0, 2), 1'b1);
    end

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
